// File: rtl/param_bus_arbiter_pkg.sv
// rtl/param_bus_arbiter_pkg.sv - shared widths, FSM states and bank indices for the parameter bus
package param_bus_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int BW_DEF     = 3;
  localparam int AW_DEF     = 7;
  localparam int DW_DEF     = 8;
  localparam int RD_LAT_DEF = 2;
  localparam bit PRIO0_DEF  = 1'b1;

  localparam int BANK_OSC = 0;
  localparam int BANK_ENV = 1;
  localparam int BANK_FLT = 2;
  localparam int BANK_MIX = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/param_bus_arbiter_if.sv
// rtl/param_bus_arbiter_if.sv - requester-side and register-bus signals of the parameter bus arbiter
interface param_bus_if
  import param_bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int BW   = BW_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*BW-1:0] req_bank;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [BW-1:0]      bank_adr;
  logic [AW-1:0]      dec_addr;
  logic [DW-1:0]      bus_wdata;
  logic               bus_we;
  logic               bus_re;
  logic [DW-1:0]      bus_rdata;
  logic               busy;

  modport master (
    input  req_valid, req_we, req_bank, req_addr, req_wdata, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, bank_adr, dec_addr, bus_wdata,
           bus_we, bus_re, busy
  );

  modport slave (
    output req_valid, req_we, req_bank, req_addr, req_wdata, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, bank_adr, dec_addr, bus_wdata,
           bus_we, bus_re, busy
  );

endinterface

// File: rtl/param_bus_arbiter_rr_pick.sv
// rtl/param_bus_arbiter_rr_pick.sv - combinational round-robin winner select with optional requester-0 override
module rr_pick #(
  parameter int NREQ  = 3,
  parameter bit PRIO0 = 1'b1,
  parameter int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_valid_o
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan upward from the pointer; the first valid requester after wrap wins.
  always_comb begin
    winner_o = ptr_i;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
    if (PRIO0 && req_valid_i[0]) begin
      winner_o = '0;
    end
  end

  assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/param_bus_arbiter.sv
// rtl/param_bus_arbiter.sv - serialises parameter register bus accesses from several requesters
module param_bus_arbiter
  import param_bus_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int BW     = BW_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter bit PRIO0  = PRIO0_DEF
) (
  input  logic        reg_clk,
  input  logic        reset_reg_N,
  param_bus_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 2;

  arb_state_e      state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   pick;
  logic            any_valid;
  logic            we_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bank_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            bus_we_q;
  logic            bus_re_q;
  logic            busy_q;
  logic [NREQ-1:0] ready_q;
  logic [NREQ-1:0] rsp_valid_q;

  rr_pick #(
    .NREQ  (NREQ),
    .PRIO0 (PRIO0)
  ) u_pick (
    .req_valid_i (bus.req_valid),
    .ptr_i       (ptr_q),
    .winner_o    (pick),
    .any_valid_o (any_valid)
  );

  // A requester-0 priority win leaves the rotation where it was.
  always_comb begin
    ptr_d = ptr_q;
    if (!(PRIO0 && bus.req_valid[0])) begin
      ptr_d = IW'(wrap_inc(int'(pick), NREQ));
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      bank_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            win_q    <= pick;
            we_q     <= bus.req_we[pick];
            bank_q   <= bus.req_bank[int'(pick)*BW +: BW];
            addr_q   <= bus.req_addr[int'(pick)*AW +: AW];
            wdata_q  <= bus.req_wdata[int'(pick)*DW +: DW];
            bus_we_q <= bus.req_we[pick];
            bus_re_q <= !bus.req_we[pick];
            ready_q  <= NREQ'(1) << pick;
            ptr_q    <= ptr_d;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt_q == '0) begin
            rdata_q     <= bus.bus_rdata;
            rsp_valid_q <= NREQ'(1) << win_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.bank_adr  = bank_q;
  assign bus.dec_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_re    = bus_re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb/tb_param_bus_arbiter.sv - scoreboard bench for round-robin and priority builds of the arbiter
module tb_param_bus_arbiter;
  import param_bus_pkg::*;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_RSP = 2'd2;

  typedef struct {
    logic [1:0] kind;
    int         idx;
    logic [2:0] bank;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic reg_clk = 1'b0;
  logic reset_reg_N;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  ev_t  q_a[$];
  ev_t  q_b[$];
  int   a_str = 0, b_str = 0, a_rsp = 0;
  int   a_last_str = 0, a_last_re = 0, b_last_str = 0;
  int   a_rr_n = 0;
  bit   rr_mode = 1'b0;
  logic [7:0] pa0, pa1;

  param_bus_if #(.NREQ(3), .BW(3), .AW(7), .DW(8)) if_a ();
  param_bus_if #(.NREQ(3), .BW(3), .AW(7), .DW(8)) if_b ();

  param_bus_arbiter #(.NREQ(3), .BW(3), .AW(7), .DW(8), .RD_LAT(2), .PRIO0(1'b0)) dut_a (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .bus         (if_a)
  );

  param_bus_arbiter #(.NREQ(3), .BW(3), .AW(7), .DW(8), .RD_LAT(2), .PRIO0(1'b1)) dut_b (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .bus         (if_b)
  );

  always #5 reg_clk = ~reg_clk;
  always @(posedge reg_clk) cyc <= cyc + 1;

  function automatic logic [7:0] bus_mem(input logic [2:0] bank, input logic [6:0] addr);
    if (bank == 3'd5 && addr == 7'h03) return 8'h3C;
    return {bank[0], addr} ^ 8'h5A;
  endfunction

  // Register bus model: data is valid RD_LAT=2 cycles after the read strobe, garbage otherwise.
  always @(posedge reg_clk) begin
    pa0 <= if_a.bus_re ? bus_mem(if_a.bank_adr, if_a.dec_addr) : 8'hEE;
    pa1 <= pa0;
  end
  assign if_a.bus_rdata = pa1;
  assign if_b.bus_rdata = 8'h00;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  always @(negedge reg_clk) begin : mon_a
    ev_t e;
    if (if_a.bus_we || if_a.bus_re) begin
      a_str <= a_str + 1;
      check("a_sb_has_access", 64'(q_a.size() != 0), 64'(1));
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_kind", 64'(if_a.bus_we ? K_WR : K_RD), 64'(e.kind));
        check("a_ready", 64'(if_a.req_ready), 64'(1) << e.idx);
        check("a_bank", 64'(if_a.bank_adr), 64'(e.bank));
        check("a_addr", 64'(if_a.dec_addr), 64'(e.addr));
        if (if_a.bus_we) check("a_wdata", 64'(if_a.bus_wdata), 64'(e.data));
        check("a_busy", 64'(if_a.busy), 64'(1));
      end
      if (rr_mode && a_rr_n > 0) check("a_rr_gap", 64'(cyc - a_last_str), 64'(2));
      if (rr_mode) a_rr_n <= a_rr_n + 1;
      a_last_str <= cyc;
      if (if_a.bus_re) a_last_re <= cyc;
    end else if (if_a.req_ready != '0) begin
      check("a_stray_ready", 64'(if_a.req_ready), 64'(0));
    end
    if (if_a.rsp_valid != '0) begin
      a_rsp <= a_rsp + 1;
      check("a_sb_has_rsp", 64'(q_a.size() != 0), 64'(1));
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_rsp_kind", 64'(K_RSP), 64'(e.kind));
        check("a_rsp_valid", 64'(if_a.rsp_valid), 64'(1) << e.idx);
        check("a_rsp_rdata", 64'(if_a.rsp_rdata), 64'(e.data));
        check("a_rsp_latency", 64'(cyc - a_last_re), 64'(3));
      end
    end
  end

  always @(negedge reg_clk) begin : mon_b
    ev_t e;
    if (if_b.bus_we || if_b.bus_re) begin
      b_str <= b_str + 1;
      b_last_str <= cyc;
      check("b_sb_has_access", 64'(q_b.size() != 0), 64'(1));
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_kind", 64'(if_b.bus_we ? K_WR : K_RD), 64'(e.kind));
        check("b_ready", 64'(if_b.req_ready), 64'(1) << e.idx);
        check("b_bank", 64'(if_b.bank_adr), 64'(e.bank));
        check("b_addr", 64'(if_b.dec_addr), 64'(e.addr));
        check("b_wdata", 64'(if_b.bus_wdata), 64'(e.data));
      end
    end
    if (if_b.rsp_valid != '0) check("b_stray_rsp", 64'(if_b.rsp_valid), 64'(0));
  end

  function automatic logic [63:0] outs_a();
    return 64'({if_a.req_ready, if_a.rsp_valid, if_a.rsp_rdata, if_a.bank_adr, if_a.dec_addr,
                if_a.bus_wdata, if_a.bus_we, if_a.bus_re, if_a.busy});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({if_b.req_ready, if_b.rsp_valid, if_b.rsp_rdata, if_b.bank_adr, if_b.dec_addr,
                if_b.bus_wdata, if_b.bus_we, if_b.bus_re, if_b.busy});
  endfunction

  task automatic set_req(input bit on_b, input int i, input bit v, input bit we,
                         input logic [2:0] bank, input logic [6:0] addr, input logic [7:0] data);
    if (on_b) begin
      if_b.req_valid[i] = v;
      if_b.req_we[i] = we;
      if_b.req_bank[i*3 +: 3] = bank;
      if_b.req_addr[i*7 +: 7] = addr;
      if_b.req_wdata[i*8 +: 8] = data;
    end else begin
      if_a.req_valid[i] = v;
      if_a.req_we[i] = we;
      if_a.req_bank[i*3 +: 3] = bank;
      if_a.req_addr[i*7 +: 7] = addr;
      if_a.req_wdata[i*8 +: 8] = data;
    end
  endtask

  task automatic push(input bit on_b, input logic [1:0] kind, input int idx,
                      input logic [2:0] bank, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind; e.idx = idx; e.bank = bank; e.addr = addr; e.data = data;
    if (on_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  function automatic int get_cnt(input int sel);
    return (sel == 0) ? a_str : (sel == 1) ? b_str : a_rsp;
  endfunction

  task automatic wait_cnt(input int sel, input int target, input string tag);
    int n = 0;
    while (get_cnt(sel) < target && n < 60) begin
      @(posedge reg_clk); #1;
      n++;
    end
    check(tag, 64'(get_cnt(sel) >= target), 64'(1));
  endtask

  initial begin
    int drop_cyc;
    reset_reg_N = 1'b0;
    if_a.req_valid = '0; if_a.req_we = '0; if_a.req_bank = '0; if_a.req_addr = '0; if_a.req_wdata = '0;
    if_b.req_valid = '0; if_b.req_we = '0; if_b.req_bank = '0; if_b.req_addr = '0; if_b.req_wdata = '0;
    repeat (3) @(posedge reg_clk);
    #1;
    check("a_reset_outputs", outs_a(), 64'(0));
    check("b_reset_outputs", outs_b(), 64'(0));
    reset_reg_N = 1'b1;
    @(posedge reg_clk); #1;

    // Round-robin: three writers held valid for six grants.
    rr_mode = 1'b1;
    for (int i = 0; i < 3; i++) set_req(0, i, 1'b1, 1'b1, 3'(i), 7'(8'h20 + i), 8'(8'h10 + i));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++) push(0, K_WR, i, 3'(i), 7'(8'h20 + i), 8'(8'h10 + i));
    wait_cnt(0, 6, "a_rr_six_grants");
    if_a.req_valid = '0;
    rr_mode = 1'b0;
    repeat (3) @(posedge reg_clk); #1;

    // Single write from requester 0.
    set_req(0, 0, 1'b1, 1'b1, 3'(BANK_FLT), 7'h15, 8'hA5);
    push(0, K_WR, 0, 3'(BANK_FLT), 7'h15, 8'hA5);
    wait_cnt(0, 7, "a_single_write");
    if_a.req_valid = '0;
    repeat (3) @(posedge reg_clk); #1;

    // Withdrawal: requester 2 is valid only in the IDLE cycle that requester 1 wins.
    set_req(0, 1, 1'b1, 1'b1, 3'(BANK_ENV), 7'h31, 8'h77);
    set_req(0, 2, 1'b1, 1'b1, 3'(BANK_MIX), 7'h42, 8'h99);
    push(0, K_WR, 1, 3'(BANK_ENV), 7'h31, 8'h77);
    @(posedge reg_clk); #1;
    if_a.req_valid[2] = 1'b0;
    wait_cnt(0, 8, "a_withdraw_grant");
    if_a.req_valid = '0;
    repeat (6) @(posedge reg_clk); #1;
    check("a_withdraw_no_extra", 64'(a_str), 64'(8));

    // Read from requester 1 through the latency model.
    set_req(0, 1, 1'b1, 1'b0, 3'(BANK_MIX), 7'h03, 8'h00);
    push(0, K_RD, 1, 3'(BANK_MIX), 7'h03, 8'h00);
    push(0, K_RSP, 1, 3'd0, 7'h00, 8'h3C);
    wait_cnt(0, 9, "a_read_issue");
    if_a.req_valid = '0;
    wait_cnt(2, 1, "a_read_rsp");
    repeat (3) @(posedge reg_clk); #1;

    // Reset while the read waits for data: no response may follow.
    set_req(0, 1, 1'b1, 1'b0, 3'(BANK_OSC), 7'h44, 8'h00);
    push(0, K_RD, 1, 3'(BANK_OSC), 7'h44, 8'h00);
    wait_cnt(0, 10, "a_reset_read_issue");
    if_a.req_valid = '0;
    #3;
    reset_reg_N = 1'b0;
    #1;
    check("a_reset_mid_read_outputs", outs_a(), 64'(0));
    repeat (2) @(posedge reg_clk); #1;
    reset_reg_N = 1'b1;
    repeat (5) @(posedge reg_clk); #1;
    check("a_reset_no_rsp", 64'(a_rsp), 64'(1));
    set_req(0, 1, 1'b1, 1'b1, 3'(BANK_FLT), 7'h11, 8'h5C);
    set_req(0, 2, 1'b1, 1'b1, 3'(BANK_FLT), 7'h22, 8'hC5);
    push(0, K_WR, 1, 3'(BANK_FLT), 7'h11, 8'h5C);
    wait_cnt(0, 11, "a_post_reset_grant");
    if_a.req_valid = '0;
    repeat (3) @(posedge reg_clk); #1;

    // Priority build: requester 0 starves requester 2 until it drops.
    set_req(1, 0, 1'b1, 1'b1, 3'(BANK_OSC), 7'h01, 8'h0F);
    set_req(1, 2, 1'b1, 1'b1, 3'(BANK_ENV), 7'h02, 8'hF0);
    for (int i = 0; i < 4; i++) push(1, K_WR, 0, 3'(BANK_OSC), 7'h01, 8'h0F);
    push(1, K_WR, 2, 3'(BANK_ENV), 7'h02, 8'hF0);
    wait_cnt(1, 4, "b_prio_four_grants");
    if_b.req_valid[0] = 1'b0;
    drop_cyc = cyc;
    wait_cnt(1, 5, "b_prio_then_req2");
    if_b.req_valid = '0;
    check("b_prio_req2_within_2", 64'((b_last_str - drop_cyc) <= 2), 64'(1));
    repeat (4) @(posedge reg_clk); #1;

    check("a_sb_drained", 64'(q_a.size()), 64'(0));
    check("b_sb_drained", 64'(q_b.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
